// File: rtl/vec_cache_ds_wb_agent.sv
// rtl/vec_cache_ds_wb_agent.sv - downstream write-back agent for evicted lines
// Buffers evict beats, issues them as downstream writes and retires lines on write acks.
package vec_cache_ds_wb_pkg;
  localparam int DATA_WIDTH           = 32;
  localparam int ADDR_WIDTH           = 32;
  localparam int MSHR_ENTRY_IDX_WIDTH = 4;
  localparam int DB_ENTRY_IDX_WIDTH   = 3;
  localparam int TXN_ID_WIDTH         = 4;
  localparam int SIDEBAND_WIDTH       = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]           data;
    logic [ADDR_WIDTH-1:0]           addr;
    logic                            last;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXN_ID_WIDTH-1:0]         txn_id;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } evict_to_ds_pld_t;
endpackage

module vec_cache_ds_wb_agent
  import vec_cache_ds_wb_pkg::*;
#(
  parameter int BEAT_FIFO_DEPTH = 8,
  parameter int OST_NUM         = 8,
  parameter int BEATS_PER_LINE  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            evict_to_ds_vld,
  input  evict_to_ds_pld_t                evict_to_ds_pld,
  output logic                            evict_to_ds_rdy,
  output logic                            ds_wr_vld,
  output evict_to_ds_pld_t                ds_wr_pld,
  input  logic                            ds_wr_rdy,
  input  logic                            ds_wr_ack_vld,
  input  logic [TXN_ID_WIDTH-1:0]         ds_wr_ack_txn_id,
  output logic                            evict_done,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_idx,
  output logic                            ost_full,
  output logic                            protocol_err
);
  localparam int PW = $clog2(BEAT_FIFO_DEPTH);
  localparam int SW = (OST_NUM > 1) ? $clog2(OST_NUM) : 1;
  localparam int CW = $clog2(BEATS_PER_LINE + 1);
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS_PER_LINE - 1);
  localparam logic [OST_NUM-1:0] VEC_ONE = 1;

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_RSV, SLOT_PEND} slot_st_t;

  evict_to_ds_pld_t fifo_mem [BEAT_FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic fifo_empty, fifo_full, push, pop;

  state_t state, state_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic [SW-1:0] cur_slot, alloc_idx, fill_slot, hit_idx;
  logic alloc, fill, fsm_err;

  slot_st_t slot_st [OST_NUM];
  logic [TXN_ID_WIDTH-1:0] slot_txn [OST_NUM];
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] slot_rob [OST_NUM];
  logic [OST_NUM-1:0] free_vec, pend_hit;
  logic ack_hit, ack_err;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign evict_to_ds_rdy = !fifo_full;
  assign push = evict_to_ds_vld && !fifo_full;
  assign pop = ds_wr_vld && ds_wr_rdy;
  assign ds_wr_pld = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= evict_to_ds_pld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_comb begin
    free_vec = '0;
    pend_hit = '0;
    for (int i = 0; i < OST_NUM; i++) begin
      free_vec[i] = (slot_st[i] == SLOT_FREE);
      pend_hit[i] = (slot_st[i] == SLOT_PEND) && (slot_txn[i] == ds_wr_ack_txn_id);
    end
  end

  // Descending scan leaves the lowest set index in place.
  always_comb begin
    alloc_idx = '0;
    hit_idx = '0;
    for (int i = OST_NUM - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = SW'(i);
      if (pend_hit[i]) hit_idx = SW'(i);
    end
  end

  assign ost_full = ~|free_vec;
  assign ack_hit = ds_wr_ack_vld && (|pend_hit);
  assign ack_err = ds_wr_ack_vld && (~|pend_hit || ((pend_hit & (pend_hit - VEC_ONE)) != '0));
  assign fill_slot = (state == IDLE) ? alloc_idx : cur_slot;

  always_comb begin
    state_nxt = state;
    beat_cnt_nxt = beat_cnt;
    ds_wr_vld = 1'b0;
    alloc = 1'b0;
    fill = 1'b0;
    fsm_err = 1'b0;
    case (state)
      IDLE: begin
        ds_wr_vld = !fifo_empty && !ost_full;
        if (pop) begin
          alloc = 1'b1;
          // A line that ends on its first beat is still tracked so its ack can retire it.
          if (BEATS_PER_LINE == 1 || ds_wr_pld.last) begin
            fill = 1'b1;
            fsm_err = (BEATS_PER_LINE > 1) || !ds_wr_pld.last;
          end else begin
            state_nxt = BURST;
            beat_cnt_nxt = CNT_ONE;
          end
        end
      end
      BURST: begin
        ds_wr_vld = !fifo_empty;
        if (pop) begin
          if (beat_cnt == CNT_LAST) begin
            fill = 1'b1;
            fsm_err = !ds_wr_pld.last;
            state_nxt = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            fsm_err = ds_wr_pld.last;
            beat_cnt_nxt = beat_cnt + CNT_ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat_cnt <= '0;
      cur_slot <= '0;
      evict_done <= 1'b0;
      evict_done_idx <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < OST_NUM; i++) begin
        slot_st[i] <= SLOT_FREE;
        slot_txn[i] <= '0;
        slot_rob[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (alloc) cur_slot <= alloc_idx;
      evict_done <= ack_hit;
      if (ack_hit) evict_done_idx <= slot_rob[hit_idx];
      if (fsm_err || ack_err) protocol_err <= 1'b1;
      // Alloc/fill target free or reserved slots, ack frees a pending one: never the same slot.
      for (int i = 0; i < OST_NUM; i++) begin
        if (alloc && alloc_idx == SW'(i)) slot_st[i] <= SLOT_RSV;
        if (fill && fill_slot == SW'(i)) begin
          slot_st[i] <= SLOT_PEND;
          slot_txn[i] <= ds_wr_pld.txn_id;
          slot_rob[i] <= ds_wr_pld.rob_entry_id;
        end
        if (ack_hit && hit_idx == SW'(i)) slot_st[i] <= SLOT_FREE;
      end
    end
  end
endmodule
